// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from a combinational instruction memory,
// buffers {pc, instruction} pairs in a small FIFO and hands them to decode
// over a valid/ready handshake. Redirects flush the FIFO and reload the PC.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instruction
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   r_pc;
  logic [95:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic [95:0]   w_head;

  // Handshake decode: push only when there is room or a slot frees this cycle.
  always_comb begin
    w_pop  = out_valid && out_ready;
    w_push = !redirect_valid && ((r_count < CW'(FIFO_DEPTH)) || w_pop);
  end

  // PC register: reset, redirect (word aligned), or advance on a successful push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= {redirect_pc[63:2], 2'b00};
    end else if (w_push) begin
      r_pc <= r_pc + 64'd4;
    end
  end

  // FIFO storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_pc, imem_instruction};
    end
  end

  // Pointers and occupancy; reset and redirect both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs: head entry read combinationally from storage.
  always_comb begin
    w_head          = r_mem[r_rptr];
    imem_pc         = r_pc;
    out_valid       = (r_count != '0);
    out_pc          = w_head[95:32];
    out_instruction = w_head[31:0];
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory. Owns the program counter and drives the memory's `pc` input. Captures the combinationally returned instruction word, with its PC, into a small FIFO. Presents it to decode through a valid/ready handshake, and handles redirects from branch/jump resolution by flushing the FIFO and reloading the PC.

## Interface
Parameters:
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `FIFO_DEPTH`, 4, number of {pc, instruction} entries buffered. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_pc`  out  64  fetch address to instruction memory; equals the internal PC register.
- `imem_instruction`  in  32  instruction word returned combinationally for `imem_pc` in the same cycle.
- `redirect_valid`  in  1  control-flow redirect request from execute.
- `redirect_pc`  in  64  redirect target; bits [1:0] ignored.
- `out_valid`  out  1  FIFO head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  64  PC of head entry.
- `out_instruction`  out  32  instruction of head entry.

## Operation
- State:
  - PC register (64 b);
  - FIFO storage of FIFO_DEPTH × 96 b;
  - read/write pointers of log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH;
  - occupancy count of log2(FIFO_DEPTH)+1 bits.
- `pop = out_valid && out_ready`.
- `push = !redirect_valid && (count < FIFO_DEPTH || pop)`. Push while full is permitted only when a pop occurs in the same cycle.
- On push:
  - write {PC, imem_instruction} at write pointer;
  - advance write pointer;
  - PC ← PC + 4, modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
- No push and no redirect: PC holds. The fetch is simply re-issued next cycle; memory is stateless.
- On pop: advance read pointer.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Redirect (`redirect_valid`=1) takes priority over everything else:
  - count ← 0;
  - read pointer ← write pointer ← 0;
  - PC ← {redirect_pc[63:2], 2'b00};
  - no push that cycle.
  - A pop handshake in the redirect cycle still counts as consumed by decode (the head was presented), but the FIFO is cleared regardless.
- `out_valid = (count != 0)`. `out_pc`/`out_instruction` = entry at read pointer, read combinationally from storage. Values are don't-care when `out_valid`=0.
- Back-to-back redirects: each one reloads the PC. The last one wins, and no instruction is pushed during any redirect cycle.

## Timing
- Reset (`rst`=1 at edge):
  - PC ← RESET_PC, count ← 0, pointers ← 0;
  - after the edge: `imem_pc`=RESET_PC, `out_valid`=0.
  - Reset overrides redirect.
  - Reset mid-operation discards all buffered entries.
- Fetch-to-decode latency: an instruction fetched in cycle N appears at the FIFO head no earlier than cycle N+1.
- First instruction after reset: valid one cycle after `rst` deasserts.
- Redirect latency: redirect asserted in cycle N.
  - cycle N+1: `imem_pc` = target, `out_valid`=0;
  - cycle N+2: target instruction valid at the head.
- Sustained throughput: 1 instruction/cycle with `out_ready` held high, including when full.
- Handshake rules:
  - `out_pc`/`out_instruction` are stable while `out_valid`=1 and `out_ready`=0, except on redirect or reset;
  - `out_valid` never drops without a pop, redirect, or reset.
- Full: with `out_ready`=0, exactly FIFO_DEPTH entries are accepted, then PC freezes at the next unfetched address.
- Empty: pop cannot occur (`out_valid`=0), so the count never underflows.

## Test plan
- Reset and stream:
  - stimulus: RESET_PC=0, memory word i = 32'h1000_0000+i, `out_ready`=1;
  - required: out_pc sequence 0,4,8,… with matching instructions, one per cycle from the first cycle after reset.
- Backpressure/full:
  - stimulus: `out_ready`=0 for 10 cycles after reset;
  - required: count saturates at 4; `imem_pc` holds 0x10; the head stays pc=0;
  - on releasing ready: pcs 0,4,8,C,10 in consecutive cycles with no gap or duplicate.
- Redirect flush:
  - stimulus: with 3 entries buffered, pulse redirect to 64'h200 for one cycle;
  - required: next cycle `out_valid`=0 and `imem_pc`=0x200; following cycle head pc=0x200.
- Misaligned redirect and priority:
  - stimulus: redirect_pc=64'h203 with `rst`=0;
  - required: PC=0x200.
  - stimulus: same cycle `rst`=1 with redirect;
  - required: PC=RESET_PC.
- PC wrap:
  - stimulus: redirect to 64'hFFFF_FFFF_FFFF_FFFC, `out_ready`=1;
  - required: next fetched PC is 0.
- Simultaneous push/pop at full:
  - stimulus: fill to 4, then assert `out_ready` for one cycle;
  - required: count stays 4; head advances by one entry; PC advances by 4.
